// File: rtl/recolector_salida_if.sv
// Bus bundle between the output-FIFO collector and its surroundings:
// FIFO read ports 4..7, the collected-word handshake and the per-port counters.
interface recolector_salida_if #(
  parameter int DATA_W = 10,
  parameter int CNT_W  = 8
);
  logic [DATA_W-1:0] fifo4_out, fifo5_out, fifo6_out, fifo7_out;
  logic              fifo4_empty, fifo5_empty, fifo6_empty, fifo7_empty;
  logic              pop4, pop5, pop6, pop7;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic [1:0]        port_id;
  logic              ready_in;
  logic [CNT_W-1:0]  cnt4, cnt5, cnt6, cnt7;
  logic              idle;

  modport master (
    input  fifo4_out, fifo5_out, fifo6_out, fifo7_out,
    input  fifo4_empty, fifo5_empty, fifo6_empty, fifo7_empty,
    input  ready_in,
    output pop4, pop5, pop6, pop7,
    output data_out, data_valid, port_id,
    output cnt4, cnt5, cnt6, cnt7, idle
  );

  modport slave (
    output fifo4_out, fifo5_out, fifo6_out, fifo7_out,
    output fifo4_empty, fifo5_empty, fifo6_empty, fifo7_empty,
    output ready_in,
    input  pop4, pop5, pop6, pop7,
    input  data_out, data_valid, port_id,
    input  cnt4, cnt5, cnt6, cnt7, idle
  );
endinterface

// File: rtl/recolector_salida.sv
// Round-robin collector: pops one of four output FIFOs, registers the word and
// holds it until downstream accepts it, keeping a saturating count per FIFO.
module recolector_salida #(
  parameter int DATA_W = 10,
  parameter int CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  recolector_salida_if.master  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, HOLD = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t                   state_q, state_d;
  logic [1:0]               rr_q, rr_d;
  logic [1:0]               gnt_q, gnt_d;
  logic [1:0]               port_id_q, port_id_d;
  logic [DATA_W-1:0]        data_out_q, data_out_d;
  logic                     data_valid_q, data_valid_d;
  logic [3:0][CNT_W-1:0]    cnt_q, cnt_d;

  logic [3:0][DATA_W-1:0]   fifo_out_s;
  logic [3:0]               empty_s;
  logic [3:0]               pop_s;
  logic [1:0]               search_s;
  logic [1:0]               pick_s;
  logic                     found_s;

  assign fifo_out_s = {bus.fifo7_out, bus.fifo6_out, bus.fifo5_out, bus.fifo4_out};
  assign empty_s    = {bus.fifo7_empty, bus.fifo6_empty, bus.fifo5_empty, bus.fifo4_empty};

  // Walk the offsets from rr downwards so the smallest offset that is non-empty wins.
  always_comb begin
    found_s  = 1'b0;
    pick_s   = rr_q;
    search_s = rr_q;
    for (int k = 3; k >= 0; k--) begin
      search_s = rr_q + 2'(k);
      found_s  = found_s | ~empty_s[search_s];
      pick_s   = empty_s[search_s] ? pick_s : search_s;
    end
  end

  // Next-state logic; the pop strobe is gated by reset so nothing is fetched while held.
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    gnt_d        = gnt_q;
    port_id_d    = port_id_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    cnt_d        = cnt_q;
    pop_s        = 4'b0000;
    case (state_q)
      IDLE: begin
        if (found_s && reset) begin
          pop_s[pick_s] = 1'b1;
          gnt_d         = pick_s;
          state_d       = READ;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        data_out_d   = fifo_out_s[gnt_q];
        port_id_d    = gnt_q;
        data_valid_d = 1'b1;
        rr_d         = gnt_q + 2'd1;
        state_d      = HOLD;
        if (cnt_q[gnt_q] != CNT_MAX) begin
          cnt_d[gnt_q] = cnt_q[gnt_q] + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_d[gnt_q] = CNT_MAX;
        end
      end
      HOLD: begin
        if (bus.ready_in) begin
          data_valid_d = 1'b0;
          state_d      = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        data_valid_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      rr_q         <= 2'd0;
      gnt_q        <= 2'd0;
      port_id_q    <= 2'd0;
      data_out_q   <= {DATA_W{1'b0}};
      data_valid_q <= 1'b0;
      cnt_q        <= {(4*CNT_W){1'b0}};
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      gnt_q        <= gnt_d;
      port_id_q    <= port_id_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.pop4       = pop_s[0];
  assign bus.pop5       = pop_s[1];
  assign bus.pop6       = pop_s[2];
  assign bus.pop7       = pop_s[3];
  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.port_id    = port_id_q;
  assign bus.cnt4       = cnt_q[0];
  assign bus.cnt5       = cnt_q[1];
  assign bus.cnt6       = cnt_q[2];
  assign bus.cnt7       = cnt_q[3];
  assign bus.idle       = (state_q == IDLE);

endmodule

// File: tb/tb_recolector_salida.sv
// Self-checking bench: four emulated FIFOs feed the collector; a transaction-level
// model (pop time, delivery time, acceptance) predicts every output each cycle.
module tb_recolector_salida;
  localparam int DATA_W = 10;
  localparam int CNT_W  = 8;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  recolector_salida_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();
  recolector_salida #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [3:0]        emp_s = 4'hF;
  logic [DATA_W-1:0] fout_s [4];
  logic              rdy_s = 1'b0;

  assign bus.fifo4_out   = fout_s[0];
  assign bus.fifo5_out   = fout_s[1];
  assign bus.fifo6_out   = fout_s[2];
  assign bus.fifo7_out   = fout_s[3];
  assign bus.fifo4_empty = emp_s[0];
  assign bus.fifo5_empty = emp_s[1];
  assign bus.fifo6_empty = emp_s[2];
  assign bus.fifo7_empty = emp_s[3];
  assign bus.ready_in    = rdy_s;

  wire [3:0]       pop_w = {bus.pop7, bus.pop6, bus.pop5, bus.pop4};
  wire [CNT_W-1:0] cnt_w [4];
  assign cnt_w[0] = bus.cnt4;
  assign cnt_w[1] = bus.cnt5;
  assign cnt_w[2] = bus.cnt6;
  assign cnt_w[3] = bus.cnt7;

  int n_vec = 0;
  int n_err = 0;

  // FIFO contents and reference model state
  logic [DATA_W-1:0] q [4][$];
  bit                m_busy = 1'b0;
  int                m_from = 0;
  int                m_port = 0;
  logic [DATA_W-1:0] m_word = '0;
  int                m_rr   = 0;
  int                m_cnt [4] = '{0, 0, 0, 0};
  int                cyc    = 0;
  int                pop_log [$];
  int                pop_cyc [$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle, entered and left on a falling edge.
  task automatic tick();
    logic [3:0] exp_pop;
    logic [3:0] act_pop;
    bit         exp_valid;
    bit         found;
    int         g;
    for (int i = 0; i < 4; i++) emp_s[i] = (q[i].size() == 0);
    #1;
    exp_pop = 4'b0000;
    g = 0;
    if (!reset) begin
      m_busy = 1'b0;
      m_rr   = 0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      check_eq("rst_pop",   32'(pop_w), 32'd0);
      check_eq("rst_idle",  32'(bus.idle), 32'd1);
      check_eq("rst_valid", 32'(bus.data_valid), 32'd0);
      check_eq("rst_data",  32'(bus.data_out), 32'd0);
      check_eq("rst_port",  32'(bus.port_id), 32'd0);
      for (int i = 0; i < 4; i++) check_eq($sformatf("rst_cnt%0d", i + 4), 32'(cnt_w[i]), 32'd0);
    end else begin
      if (m_busy && cyc == m_from && m_cnt[m_port] < CMAX) m_cnt[m_port]++;
      exp_valid = m_busy && (cyc >= m_from);
      found = 1'b0;
      if (!m_busy) begin
        for (int k = 0; k < 4; k++) begin
          if (!found && q[(m_rr + k) % 4].size() != 0) begin
            found = 1'b1;
            g = (m_rr + k) % 4;
          end
        end
      end
      if (found) exp_pop[g] = 1'b1;
      check_eq("pop",   32'(pop_w), 32'(exp_pop));
      check_eq("idle",  32'(bus.idle), 32'(!m_busy));
      check_eq("valid", 32'(bus.data_valid), 32'(exp_valid));
      if (exp_valid) begin
        check_eq("data", 32'(bus.data_out), 32'(m_word));
        check_eq("port", 32'(bus.port_id), 32'(m_port));
      end
      for (int i = 0; i < 4; i++) check_eq($sformatf("cnt%0d", i + 4), 32'(cnt_w[i]), 32'(m_cnt[i]));
      if (found) begin
        m_busy = 1'b1;
        m_from = cyc + 2;
        m_port = g;
        m_word = q[g][0];
        m_rr   = (g + 1) % 4;
        pop_log.push_back(g);
        pop_cyc.push_back(cyc);
      end else if (exp_valid && rdy_s) begin
        m_busy = 1'b0;
      end
    end
    act_pop = pop_w;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (act_pop[i] && q[i].size() != 0) fout_s[i] = q[i].pop_front();
      else                               fout_s[i] = DATA_W'($urandom);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) fout_s[i] = '0;
    @(negedge clk);

    // Reset held with FIFO4 non-empty: no pop, everything cleared
    q[0].push_back(10'h155);
    tick();
    tick();
    reset = 1'b1;

    // Single word from FIFO4 with ready high
    rdy_s = 1'b1;
    repeat (5) tick();

    // All four FIFOs loaded: strict round robin, 3-cycle pop spacing
    do_reset();
    for (int i = 0; i < 4; i++) repeat (2) q[i].push_back(DATA_W'($urandom));
    pop_log.delete();
    pop_cyc.delete();
    repeat (26) tick();
    begin
      int exp_order [5] = '{0, 1, 2, 3, 0};
      for (int i = 0; i < 5; i++) check_eq($sformatf("rr_order%0d", i), 32'(pop_log[i]), 32'(exp_order[i]));
      for (int i = 0; i < 4; i++) check_eq($sformatf("pop_gap%0d", i), 32'(pop_cyc[i+1] - pop_cyc[i]), 32'd3);
    end

    // Held word: ready low for 5 valid cycles, then accepted
    q[2].push_back(10'h2A7);
    rdy_s = 1'b0;
    repeat (7) tick();
    rdy_s = 1'b1;
    repeat (3) tick();

    // Asynchronous reset while holding a word
    q[1].push_back(10'h0C3);
    rdy_s = 1'b0;
    repeat (4) tick();
    #2 reset = 1'b0;
    #1;
    check_eq("arst_valid", 32'(bus.data_valid), 32'd0);
    check_eq("arst_idle",  32'(bus.idle), 32'd1);
    check_eq("arst_cnt5",  32'(bus.cnt5), 32'd0);
    check_eq("arst_pop",   32'(pop_w), 32'd0);
    @(negedge clk);
    tick();
    reset = 1'b1;
    rdy_s = 1'b1;

    // All FIFOs empty for 10 cycles
    for (int i = 0; i < 10; i++) begin
      rdy_s = 1'($urandom);
      tick();
    end

    // 300 words from FIFO5 only: counter saturates
    do_reset();
    rdy_s = 1'b1;
    repeat (300) q[1].push_back(DATA_W'($urandom));
    repeat (905) tick();
    check_eq("cnt5_sat", 32'(bus.cnt5), 32'(CMAX));
    check_eq("cnt4_zero", 32'(bus.cnt4), 32'd0);

    // Random traffic and backpressure
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) q[$urandom_range(0, 3)].push_back(DATA_W'($urandom));
      rdy_s = ($urandom_range(0, 9) < 7);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
